// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Walks a song ROM one entry at a time and presents each note
//               (duration code + pitch code) to a downstream duration FSM and
//               tone generator. Handles play edge detection, stop abort,
//               looping and end-of-song detection (marker codes or address
//               exhaustion).
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              play,
    input  logic              stop,
    input  logic              loop,
    input  logic              nextNote,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic [2:0]        duration,
    output logic [6:0]        pitch,
    output logic              rest,
    output logic              busy,
    output logic              song_done
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_PLAY = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        note;
    logic              prev_play;
    // Set once play has been seen low since reset, so that a play level held
    // high through a reset is not mistaken for a fresh rising edge.
    logic              seen_low;

    logic [2:0]        code_in;
    logic              code_valid;

    assign code_in    = rom_data[9:7];
    assign code_valid = (code_in >= 3'd1) && (code_in <= 3'd5);

    // Main sequencer: state, address, captured note and the song_done pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            addr      <= START;
            note      <= '0;
            prev_play <= 1'b0;
            seen_low  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            prev_play <= play;
            if (!play) begin
                seen_low <= 1'b1;
            end
            song_done <= 1'b0;

            if (stop) begin
                state <= S_IDLE;
                addr  <= START;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (play && !prev_play && seen_low) begin
                            state <= S_READ;
                            addr  <= START;
                        end
                    end
                    S_READ: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        note <= rom_data;
                        if (code_valid) begin
                            state <= S_PLAY;
                        end else if (loop) begin
                            state <= S_READ;
                            addr  <= START;
                        end else begin
                            state     <= S_IDLE;
                            addr      <= START;
                            song_done <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (nextNote) begin
                            if (&addr) begin
                                // Last addressable entry consumed: end of song.
                                if (loop) begin
                                    state <= S_READ;
                                    addr  <= START;
                                end else begin
                                    state     <= S_IDLE;
                                    addr      <= START;
                                    song_done <= 1'b1;
                                end
                            end else begin
                                state <= S_READ;
                                addr  <= addr + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        addr  <= START;
                    end
                endcase
            end
        end
    end

    // Outputs decoded purely from registered state and the captured note.
    always_comb begin
        rom_en   = (state == S_READ);
        rom_addr = addr;
        busy     = (state != S_IDLE);
        duration = 3'd0;
        pitch    = 7'd0;
        rest     = 1'b0;
        if (state == S_PLAY) begin
            duration = note[9:7];
            pitch    = note[6:0];
            rest     = (note[6:0] == 7'd0);
        end
    end

endmodule
`default_nettype wire
